// File: rtl/execute_pkg.sv
// Shared Y86-64 execute-stage constants, FSM state type and condition evaluation.
package execute_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  localparam logic [3:0] ALU_MUL = 4'h4;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {StIdle, StMul, StDone} mul_state_e;

  // cc is {ZF, SF, OF}
  function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
    logic zf, sf, of;
    {zf, sf, of} = cc;
    case (ifun)
      C_YES:   return 1'b1;
      C_LE:    return (sf ^ of) | zf;
      C_L:     return sf ^ of;
      C_E:     return zf;
      C_NE:    return ~zf;
      C_GE:    return ~(sf ^ of);
      C_G:     return ~(sf ^ of) & ~zf;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_pipe_if.sv
// E-stage decoded-instruction handshake into the execute stage.
interface execute_pipe_if #(
  parameter int unsigned DATA_W = 64
);
  logic              e_valid;
  logic              e_ready;
  logic [3:0]        e_icode;
  logic [3:0]        e_ifun;
  logic [DATA_W-1:0] e_valC;
  logic [DATA_W-1:0] e_valA;
  logic [DATA_W-1:0] e_valB;
  logic [3:0]        e_dstE;
  logic [3:0]        e_dstM;
  logic [1:0]        e_stat;

  modport master (
    output e_valid, e_icode, e_ifun, e_valC, e_valA, e_valB, e_dstE, e_dstM, e_stat,
    input  e_ready
  );

  modport slave (
    input  e_valid, e_icode, e_ifun, e_valC, e_valA, e_valB, e_dstE, e_dstM, e_stat,
    output e_ready
  );
endinterface

// File: rtl/alu_cc.sv
// Combinational OPq ALU (add/sub/and/xor) with Y86 condition-code flags.
module alu_cc
  import execute_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [3:0]        alu_fun_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] val_o,
  output logic              zf_o,
  output logic              sf_o,
  output logic              of_o
);
  logic sa, sb, se;

  always_comb begin
    val_o = '0;
    case (alu_fun_i)
      ALU_ADD: val_o = b_i + a_i;
      ALU_SUB: val_o = b_i - a_i;
      ALU_AND: val_o = b_i & a_i;
      ALU_XOR: val_o = b_i ^ a_i;
      default: val_o = '0;
    endcase
  end

  assign sa   = a_i[DATA_W-1];
  assign sb   = b_i[DATA_W-1];
  assign se   = val_o[DATA_W-1];
  assign zf_o = (val_o == '0);
  assign sf_o = se;

  always_comb begin
    of_o = 1'b0;
    if (alu_fun_i == ALU_ADD) of_o = (sa == sb) && (se != sa);
    else if (alu_fun_i == ALU_SUB) of_o = (sa != sb) && (se != sb);
  end
endmodule

// File: rtl/execute_pipe.sv
// Y86-64 execute stage: valE/cnd, CC register, iterative mulq, E->M pipeline register.
module execute_pipe
  import execute_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MUL_STEP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  execute_pipe_if.slave     e_if,
  input  logic              set_cc_inhibit,
  input  logic              m_stall,
  input  logic              m_bubble,
  output logic [DATA_W-1:0] fwd_valE,
  output logic [3:0]        fwd_dstE,
  output logic [2:0]        cc,
  output logic              m_valid,
  output logic [3:0]        m_icode,
  output logic              m_cnd,
  output logic [DATA_W-1:0] m_valE,
  output logic [DATA_W-1:0] m_valA,
  output logic [3:0]        m_dstE,
  output logic [3:0]        m_dstM,
  output logic [1:0]        m_stat
);
  localparam int unsigned      N        = DATA_W / MUL_STEP;
  localparam int unsigned      CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [DATA_W-1:0] BYTES   = DATA_W'(DATA_W / 8);

  mul_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] mcand_q, mplier_q, prod_q, step_sum;
  logic [2:0]        cc_q, cc_new;
  logic [DATA_W-1:0] alu_val, val_e;
  logic              alu_zf, alu_sf, alu_of;
  logic              is_opq, is_mul, bad_op, cnd, accept, cc_we;

  alu_cc #(.DATA_W(DATA_W)) u_alu_cc (
    .alu_fun_i (e_if.e_ifun),
    .a_i       (e_if.e_valA),
    .b_i       (e_if.e_valB),
    .val_o     (alu_val),
    .zf_o      (alu_zf),
    .sf_o      (alu_sf),
    .of_o      (alu_of)
  );

  assign is_opq = (e_if.e_icode == I_OPQ);
  assign is_mul = is_opq && (e_if.e_ifun == ALU_MUL);
  assign bad_op = is_opq && (e_if.e_ifun > ALU_MUL);
  assign cnd    = ((e_if.e_icode == I_RRMOVQ) || (e_if.e_icode == I_JXX)) &&
                  cond_eval(e_if.e_ifun, cc_q);

  assign e_if.e_ready = !m_stall && (!is_mul || (state_q == StDone));
  assign accept       = e_if.e_valid && e_if.e_ready;
  assign cc_we        = accept && is_opq && !bad_op && (e_if.e_stat == STAT_AOK) &&
                        !set_cc_inhibit;

  always_comb begin
    val_e = '0;
    case (e_if.e_icode)
      I_RRMOVQ:          val_e = e_if.e_valA;
      I_IRMOVQ:          val_e = e_if.e_valC;
      I_RMMOVQ, I_MRMOVQ: val_e = e_if.e_valB + e_if.e_valC;
      I_OPQ: begin
        if (is_mul)       val_e = (state_q == StDone) ? prod_q : '0;
        else if (!bad_op) val_e = alu_val;
      end
      I_CALL, I_PUSHQ:   val_e = e_if.e_valB - BYTES;
      I_RET, I_POPQ:     val_e = e_if.e_valB + BYTES;
      default:           val_e = '0;
    endcase
  end

  assign cc_new   = is_mul ? {prod_q == '0, prod_q[DATA_W-1], 1'b0} : {alu_zf, alu_sf, alu_of};
  assign fwd_valE = val_e;
  assign fwd_dstE = (!e_if.e_valid || ((e_if.e_icode == I_RRMOVQ) && !cnd)) ? REG_NONE
                                                                           : e_if.e_dstE;
  assign cc       = cc_q;

  // Shift-and-add over the low MUL_STEP multiplier bits
  always_comb begin
    step_sum = '0;
    for (int i = 0; i < int'(MUL_STEP); i++) begin
      if (mplier_q[i]) step_sum = step_sum + (mcand_q << i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (m_bubble) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else if (!m_stall) begin
      case (state_q)
        StIdle: begin
          if (e_if.e_valid && is_mul) begin
            state_q  <= StMul;
            mcand_q  <= e_if.e_valB;
            mplier_q <= e_if.e_valA;
            prod_q   <= '0;
            cnt_q    <= '0;
          end
        end
        StMul: begin
          prod_q   <= prod_q + step_sum;
          mcand_q  <= mcand_q << MUL_STEP;
          mplier_q <= mplier_q >> MUL_STEP;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_q <= StDone;
        end
        StDone: begin
          if (e_if.e_valid) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q    <= 3'b100;
      m_valid <= 1'b0;
      m_icode <= I_NOP;
      m_cnd   <= 1'b0;
      m_valE  <= '0;
      m_valA  <= '0;
      m_dstE  <= REG_NONE;
      m_dstM  <= REG_NONE;
      m_stat  <= STAT_AOK;
    end else if (m_bubble || (!m_stall && !accept)) begin
      m_valid <= 1'b0;
      m_icode <= I_NOP;
      m_cnd   <= 1'b0;
      m_valE  <= '0;
      m_valA  <= '0;
      m_dstE  <= REG_NONE;
      m_dstM  <= REG_NONE;
      m_stat  <= STAT_AOK;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_icode <= e_if.e_icode;
      m_cnd   <= cnd;
      m_valE  <= val_e;
      m_valA  <= e_if.e_valA;
      m_dstE  <= fwd_dstE;
      m_dstM  <= e_if.e_dstM;
      m_stat  <= bad_op ? STAT_INS : e_if.e_stat;
      if (cc_we) cc_q <= cc_new;
    end
  end
endmodule

// File: tb/tb_execute_pipe.sv
// Randomized self-checking bench for execute_pipe against a transaction-level Y86 model.
module tb_execute_pipe;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned MUL_STEP = 4;
  localparam int unsigned N        = DATA_W / MUL_STEP;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              set_cc_inhibit, m_stall, m_bubble;
  logic [DATA_W-1:0] fwd_valE, m_valE, m_valA;
  logic [3:0]        fwd_dstE, m_icode, m_dstE, m_dstM;
  logic [2:0]        cc;
  logic              m_valid, m_cnd;
  logic [1:0]        m_stat;

  int checks = 0;
  int errors = 0;

  logic [2:0]  ref_cc;
  logic        ref_m_valid;
  logic [63:0] ref_m_vale;

  always #5 clk = ~clk;

  execute_pipe_if #(.DATA_W(DATA_W)) e_if ();

  execute_pipe #(.DATA_W(DATA_W), .MUL_STEP(MUL_STEP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .e_if           (e_if),
    .set_cc_inhibit (set_cc_inhibit),
    .m_stall        (m_stall),
    .m_bubble       (m_bubble),
    .fwd_valE       (fwd_valE),
    .fwd_dstE       (fwd_dstE),
    .cc             (cc),
    .m_valid        (m_valid),
    .m_icode        (m_icode),
    .m_cnd          (m_cnd),
    .m_valE         (m_valE),
    .m_valA         (m_valA),
    .m_dstE         (m_dstE),
    .m_dstM         (m_dstM),
    .m_stat         (m_stat)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_vale(input logic [3:0] ic, input logic [3:0] fn,
                                           input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] c);
    case (ic)
      4'h2: return a;
      4'h3: return c;
      4'h4, 4'h5: return b + c;
      4'h6: begin
        case (fn)
          4'h0: return b + a;
          4'h1: return b - a;
          4'h2: return b & a;
          4'h3: return b ^ a;
          4'h4: return b * a;
          default: return 64'd0;
        endcase
      end
      4'h8, 4'hA: return b - 64'd8;
      4'h9, 4'hB: return b + 64'd8;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic ref_of(input logic [3:0] fn, input logic [63:0] a,
                                  input logic [63:0] b, input logic [63:0] e);
    longint sa, sb, se;
    sa = $signed(a);
    sb = $signed(b);
    se = $signed(e);
    if (fn == 4'h0) return (sa >= 0 && sb >= 0 && se < 0) || (sa < 0 && sb < 0 && se >= 0);
    if (fn == 4'h1) return (sb >= 0 && sa < 0 && se < 0) || (sb < 0 && sa >= 0 && se >= 0);
    return 1'b0;
  endfunction

  function automatic logic ref_cnd(input logic [3:0] ic, input logic [3:0] fn,
                                   input logic [2:0] c);
    logic zf, sf, of, lt;
    if (ic != 4'h2 && ic != 4'h7) return 1'b0;
    zf = c[2];
    sf = c[1];
    of = c[0];
    lt = (sf != of);
    case (fn)
      4'h0: return 1'b1;
      4'h1: return lt || zf;
      4'h2: return lt;
      4'h3: return zf;
      4'h4: return !zf;
      4'h5: return !lt;
      4'h6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic [3:0] dste,
                       input logic [3:0] dstm, input logic [1:0] st);
    e_if.e_valid = 1'b1;
    e_if.e_icode = ic;
    e_if.e_ifun  = fn;
    e_if.e_valA  = a;
    e_if.e_valB  = b;
    e_if.e_valC  = c;
    e_if.e_dstE  = dste;
    e_if.e_dstM  = dstm;
    e_if.e_stat  = st;
  endtask

  // One instruction from presentation to M-stage, with optional stall before transfer.
  task automatic run_txn(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] c, input logic [3:0] dste,
                         input logic [3:0] dstm, input logic [1:0] st, input logic inh,
                         input int nstall);
    logic [63:0] exp_e;
    logic        exp_cnd, mul, bad;
    logic [3:0]  exp_dst;
    int          w;
    exp_e   = ref_vale(ic, fn, a, b, c);
    mul     = (ic == 4'h6) && (fn == 4'h4);
    bad     = (ic == 4'h6) && (fn > 4'h4);
    exp_cnd = ref_cnd(ic, fn, ref_cc);
    exp_dst = (ic == 4'h2 && !exp_cnd) ? 4'hF : dste;
    set_cc_inhibit = inh;
    drive(ic, fn, a, b, c, dste, dstm, st);
    #1;
    check("fwd_dstE", {60'd0, fwd_dstE}, {60'd0, exp_dst});
    if (mul) begin
      w = 0;
      while (!e_if.e_ready && w < 40) begin
        @(posedge clk);
        #1;
        w++;
      end
      check("mul_latency", 64'(w), 64'(N + 1));
      ref_m_valid = 1'b0;
      ref_m_vale  = 64'd0;
    end
    check("e_ready", {63'd0, e_if.e_ready}, 64'd1);
    check("fwd_valE", fwd_valE, exp_e);
    if (nstall > 0) begin
      m_stall = 1'b1;
      #1;
      check("ready_in_stall", {63'd0, e_if.e_ready}, 64'd0);
      repeat (nstall) @(posedge clk);
      #1;
      check("stall_m_valid", {63'd0, m_valid}, {63'd0, ref_m_valid});
      check("stall_m_valE", m_valE, ref_m_vale);
      check("stall_cc", {61'd0, cc}, {61'd0, ref_cc});
      m_stall = 1'b0;
      #1;
    end
    @(posedge clk);
    #1;
    if (ic == 4'h6 && !bad && st == 2'd0 && !inh)
      ref_cc = {exp_e == 64'd0, exp_e[63], (fn == 4'h4) ? 1'b0 : ref_of(fn, a, b, exp_e)};
    ref_m_valid = 1'b1;
    ref_m_vale  = exp_e;
    check("m_valid", {63'd0, m_valid}, 64'd1);
    check("m_icode", {60'd0, m_icode}, {60'd0, ic});
    check("m_valE", m_valE, exp_e);
    check("m_valA", m_valA, a);
    check("m_cnd", {63'd0, m_cnd}, {63'd0, exp_cnd});
    check("m_dstE", {60'd0, m_dstE}, {60'd0, exp_dst});
    check("m_dstM", {60'd0, m_dstM}, {60'd0, dstm});
    check("m_stat", {62'd0, m_stat}, {62'd0, bad ? 2'd3 : st});
    check("cc", {61'd0, cc}, {61'd0, ref_cc});
    set_cc_inhibit = 1'b0;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, {63'd0, m_valid}, 64'd0);
    check({tag, "_icode"}, {60'd0, m_icode}, 64'd1);
    check({tag, "_dstE"}, {60'd0, m_dstE}, 64'hF);
    check({tag, "_dstM"}, {60'd0, m_dstM}, 64'hF);
    check({tag, "_stat"}, {62'd0, m_stat}, 64'd0);
    check({tag, "_valE"}, m_valE, 64'd0);
    check({tag, "_cc"}, {61'd0, cc}, {61'd0, ref_cc});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0]  ic, fn;
    logic [63:0] a, b, c;
    logic [1:0]  st;

    set_cc_inhibit = 1'b0;
    m_stall        = 1'b0;
    m_bubble       = 1'b0;
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 2'd0);
    e_if.e_valid = 1'b0;
    ref_cc       = 3'b100;
    ref_m_valid  = 1'b0;
    ref_m_vale   = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check_bubble("reset");
    check("reset_ready", {63'd0, e_if.e_ready}, 64'd1);
    rst_n = 1'b1;

    // Directed flag and condition cases
    run_txn(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h3, 4'hF, 2'd0, 1'b0, 0);
    run_txn(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h3, 4'hF, 2'd0, 1'b0, 0);
    run_txn(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2, 4'hF, 2'd0, 1'b0, 0);
    run_txn(4'h2, 4'h2, 64'h1234, 64'd0, 64'd0, 4'h5, 4'hF, 2'd0, 1'b0, 0);
    run_txn(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h3, 4'hF, 2'd0, 1'b0, 0);
    run_txn(4'h2, 4'h2, 64'h1234, 64'd0, 64'd0, 4'h5, 4'hF, 2'd0, 1'b0, 0);

    // Multiplier: plain, stalled in DONE, bubbled mid-run, reset mid-run
    run_txn(4'h6, 4'h4, 64'd7, 64'd6, 64'd0, 4'h1, 4'hF, 2'd0, 1'b0, 0);
    run_txn(4'h6, 4'h4, 64'd3, 64'd5, 64'd0, 4'h1, 4'hF, 2'd0, 1'b0, 3);

    drive(4'h6, 4'h4, 64'd9, 64'd9, 64'd0, 4'h4, 4'hF, 2'd0);
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    m_bubble = 1'b1;
    @(posedge clk);
    #1;
    m_bubble    = 1'b0;
    ref_m_valid = 1'b0;
    ref_m_vale  = 64'd0;
    check_bubble("bubble");
    run_txn(4'h6, 4'h4, 64'd9, 64'd9, 64'd0, 4'h4, 4'hF, 2'd0, 1'b0, 0);

    drive(4'h6, 4'h4, 64'd11, 64'd13, 64'd0, 4'h4, 4'hF, 2'd0);
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    ref_cc = 3'b100;
    #2;
    check_bubble("rstmul");
    rst_n = 1'b1;
    run_txn(4'h6, 4'h4, 64'd11, 64'd13, 64'd0, 4'h4, 4'hF, 2'd0, 1'b0, 0);

    for (int n = 0; n < 150; n++) begin
      ic = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) ic = 4'h6;
      fn = 4'($urandom_range(0, 7));
      if (ic == 4'h6 && fn == 4'h4 && $urandom_range(0, 1) == 0) fn = 4'h0;
      a  = rnd_op();
      b  = rnd_op();
      c  = rnd_op();
      st = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      run_txn(ic, fn, a, b, c, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), st,
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0) ? 1 : 0);
      if ($urandom_range(0, 9) == 0) begin
        e_if.e_valid = 1'b0;
        #1;
        check("idle_fwd_dstE", {60'd0, fwd_dstE}, 64'hF);
        @(posedge clk);
        #1;
        ref_m_valid = 1'b0;
        ref_m_vale  = 64'd0;
        check_bubble("idle");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
